// File: rtl/fp32_to_int32_pipe.sv
// fp32_to_int32_pipe: two-stage binary32 -> int32 converter with per-transaction
// rounding mode, saturation and invalid/overflow/inexact flags.
// Stage 1 unpacks, classifies and aligns the significand into an integer
// magnitude plus guard/sticky bits. Stage 2 rounds, saturates and negates.
module fp32_to_int32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_overflow,
    output logic        out_inexact
);

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // ---------------- stage 1 state ----------------
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic        r_s1_nan;
    logic        r_s1_inf;
    logic        r_s1_ovf;
    logic [32:0] r_s1_mag;
    logic        r_s1_guard;
    logic        r_s1_sticky;
    logic [1:0]  r_s1_rm;

    // ---------------- stage 2 (output) state ----------------
    logic        r_s2_valid;
    logic [31:0] r_out_data;
    logic        r_out_invalid;
    logic        r_out_overflow;
    logic        r_out_inexact;

    // Handshake: stage 1 can move on whenever stage 2 is empty or draining.
    logic w_s1_adv;
    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign out_valid = r_s2_valid;

    // ---------------- stage 1 combinational ----------------
    logic              w_sign;
    logic [7:0]        w_exp;
    logic [22:0]       w_man;
    logic [23:0]       w_sig;
    logic signed [9:0] w_e;
    logic [3:0]        w_lsh;
    logic [4:0]        w_rsh;
    logic [47:0]       w_rext;
    logic              w_nan;
    logic              w_inf;
    logic              w_pre_ovf;
    logic [32:0]       w_mag;
    logic              w_guard;
    logic              w_sticky;

    // Unpack and align: the significand is placed above a 24-bit fraction field
    // so a single right shift yields magnitude, guard and sticky together
    // (shift of 24 covers e = -1, where the whole significand is fraction).
    always_comb begin
        w_sign    = in_data[31];
        w_exp     = in_data[30:23];
        w_man     = in_data[22:0];
        w_sig     = {(w_exp != 8'd0), w_man};
        w_e       = $signed({2'b00, w_exp}) - 10'sd127;
        w_lsh     = '0;
        w_rsh     = '0;
        w_rext    = '0;
        w_nan     = 1'b0;
        w_inf     = 1'b0;
        w_pre_ovf = 1'b0;
        w_mag     = '0;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        if (w_exp == 8'hFF) begin
            w_nan = (w_man != 23'd0);
            w_inf = (w_man == 23'd0);
        end else if (w_exp == 8'd0) begin
            // zero / denormal: all fraction, never reaches the guard position
            w_sticky = (w_man != 23'd0);
        end else if (w_e >= 10'sd32) begin
            w_pre_ovf = 1'b1;
        end else if (w_e >= 10'sd23) begin
            w_lsh = 4'(w_e - 10'sd23);
            w_mag = {9'd0, w_sig} << w_lsh;
        end else if (w_e >= -10'sd1) begin
            w_rsh    = 5'(10'sd23 - w_e);
            w_rext   = {w_sig, 24'd0} >> w_rsh;
            w_mag    = {9'd0, w_rext[47:24]};
            w_guard  = w_rext[23];
            w_sticky = |w_rext[22:0];
        end else begin
            // |x| < 0.5 and nonzero: only sticky survives
            w_sticky = 1'b1;
        end
    end

    // Stage 1 register: load on input transfer, hold while stage 2 is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_nan    <= 1'b0;
            r_s1_inf    <= 1'b0;
            r_s1_ovf    <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_rm     <= RM_RNE;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign   <= w_sign;
                r_s1_nan    <= w_nan;
                r_s1_inf    <= w_inf;
                r_s1_ovf    <= w_pre_ovf;
                r_s1_mag    <= w_mag;
                r_s1_guard  <= w_guard;
                r_s1_sticky <= w_sticky;
                r_s1_rm     <= in_rm;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic        w_inc;
    logic [32:0] w_rnd;
    logic [31:0] w_res;
    logic        w_invalid;
    logic        w_overflow;
    logic        w_inexact;

    // Round, then saturate against the signed range; flags are exclusive
    // because each branch sets exactly one.
    always_comb begin
        w_inc = 1'b0;
        unique case (r_s1_rm)
            RM_RNE: w_inc = r_s1_guard && (r_s1_sticky || r_s1_mag[0]);
            RM_RTZ: w_inc = 1'b0;
            RM_RDN: w_inc = r_s1_sign && (r_s1_guard || r_s1_sticky);
            RM_RUP: w_inc = !r_s1_sign && (r_s1_guard || r_s1_sticky);
            default: w_inc = 1'b0;
        endcase
        w_rnd      = r_s1_mag + {32'd0, w_inc};
        w_res      = '0;
        w_invalid  = 1'b0;
        w_overflow = 1'b0;
        w_inexact  = 1'b0;
        if (r_s1_nan) begin
            w_res     = INT_MAX;
            w_invalid = 1'b1;
        end else if (!r_s1_sign && (r_s1_inf || r_s1_ovf || w_rnd > {1'b0, INT_MAX})) begin
            w_res      = INT_MAX;
            w_overflow = 1'b1;
        end else if (r_s1_sign && (r_s1_inf || r_s1_ovf || w_rnd > {1'b0, INT_MIN})) begin
            w_res      = INT_MIN;
            w_overflow = 1'b1;
        end else begin
            w_res     = r_s1_sign ? (32'd0 - w_rnd[31:0]) : w_rnd[31:0];
            w_inexact = r_s1_guard || r_s1_sticky;
        end
    end

    // Stage 2 register: payload only changes when the held result is consumed
    // (or the stage is empty), keeping it stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid     <= 1'b0;
            r_out_data     <= '0;
            r_out_invalid  <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_inexact  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data     <= w_res;
                r_out_invalid  <= w_invalid;
                r_out_overflow <= w_overflow;
                r_out_inexact  <= w_inexact;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_invalid  = r_out_invalid;
    assign out_overflow = r_out_overflow;
    assign out_inexact  = r_out_inexact;

endmodule
